// File: rtl/truth_table_checker_pkg.sv
// Shared definitions for the truth-table response checker: FSM state
// encodings, the default input count and table-depth helpers.
package truth_table_checker_pkg;

  // Default number of DUT inputs; the truth table holds 2**N_IN entries.
  localparam int DEFAULT_N_IN = 4;

  // Width of the settle counter; SETTLE is legal from 1 to 15.
  localparam int SETTLE_W = 4;

  // Checker FSM states (2-bit encoding).
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_SETTLE  = 2'd2,
    ST_DONE    = 2'd3
  } tt_state_t;

  // Number of truth-table rows for a given input count.
  function automatic int tt_depth(input int n_in);
    return 1 << n_in;
  endfunction

  // One-hot row select for a table index.
  function automatic logic [tt_depth(DEFAULT_N_IN)-1:0] tt_onehot(
    input logic [DEFAULT_N_IN-1:0] idx
  );
    logic [tt_depth(DEFAULT_N_IN)-1:0] sel;
    sel = {{(tt_depth(DEFAULT_N_IN)-1){1'b0}}, 1'b1};
    return sel << idx;
  endfunction

endpackage

// File: rtl/truth_table_checker_settle_timer.sv
// tt_settle_timer: loadable down-counter with a zero flag. Counts down while
// enabled and parks at zero. Used for the settle wait and, when the watchdog
// is built in, as the idle-cycle watchdog.
module tt_settle_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic [W-1:0] count,
  output logic         zero
);

  logic [W-1:0] count_r;

  // Load has priority; otherwise step down while enabled, stopping at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= {W{1'b0}};
    end else if (load) begin
      count_r <= load_val;
    end else if (en && (count_r != {W{1'b0}})) begin
      count_r <= count_r - {{(W-1){1'b0}}, 1'b1};
    end else begin
      count_r <= count_r;
    end
  end

  assign count = count_r;
  assign zero  = (count_r == {W{1'b0}});

endmodule

// File: rtl/truth_table_checker.sv
// truth_table_checker: samples a DUT output a fixed settle time after each
// applied vector, builds the captured truth table, compares it against the
// expected minterm mask and reports pass/fail once every index is covered.
// Optional idle watchdog: define CHECKER_TIMEOUT_EN to build it in.
module truth_table_checker
  import truth_table_checker_pkg::*;
#(
  parameter int                   N_IN     = DEFAULT_N_IN,
  parameter logic [(1<<N_IN)-1:0] EXP_MASK = 16'h0000,
  parameter int                   SETTLE   = 2,
  parameter int                   TIMEOUT  = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 vec_valid,
  input  logic [N_IN-1:0]      vec_idx,
  input  logic                 f,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [(1<<N_IN)-1:0] captured,
  output logic [N_IN:0]        err_count,
  output logic [N_IN-1:0]      first_err_idx,
  output logic                 dup_seen,
  output logic                 overrun,
  output logic                 timeout
);

  localparam int DEPTH = 1 << N_IN;
  localparam logic [SETTLE_W-1:0] SETTLE_LOAD = SETTLE_W'(SETTLE - 1);
  localparam logic [N_IN:0]       ERR_MAX     = (N_IN + 1)'(DEPTH);
  localparam logic [N_IN:0]       ERR_ONE     = {{N_IN{1'b0}}, 1'b1};

  tt_state_t            state_r;
  logic [N_IN-1:0]      idx_r;
  logic [DEPTH-1:0]     cov_r;
  logic [DEPTH-1:0]     captured_r;
  logic [N_IN:0]        err_count_r;
  logic [N_IN-1:0]      first_err_idx_r;
  logic                 busy_r;
  logic                 done_r;
  logic                 pass_r;
  logic                 dup_seen_r;
  logic                 overrun_r;
  logic                 timeout_r;

  logic                 settle_load_s;
  logic                 settle_en_s;
  logic [SETTLE_W-1:0]  settle_count_s;
  logic                 settle_zero_s;
  logic                 sample_s;
  logic                 is_new_s;
  logic                 mismatch_s;
  logic [DEPTH-1:0]     sel_s;
  logic [DEPTH-1:0]     cov_next_s;
  logic                 all_cov_s;
  logic [N_IN:0]        err_next_s;
  logic                 wd_fire_s;

  // Settle timer control: load on an accepted vector, count while waiting.
  always_comb begin
    settle_load_s = 1'b0;
    settle_en_s   = 1'b0;
    if (!start && (state_r == ST_COLLECT) && vec_valid) begin
      settle_load_s = 1'b1;
    end else begin
      settle_load_s = 1'b0;
    end
    if (state_r == ST_SETTLE) begin
      settle_en_s = 1'b1;
    end else begin
      settle_en_s = 1'b0;
    end
  end

  tt_settle_timer #(
    .W (SETTLE_W)
  ) u_settle (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (settle_load_s),
    .load_val (SETTLE_LOAD),
    .en       (settle_en_s),
    .count    (settle_count_s),
    .zero     (settle_zero_s)
  );

`ifdef CHECKER_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_LOAD = WD_W'(TIMEOUT - 1);

  logic            wd_load_s;
  logic            wd_en_s;
  logic [WD_W-1:0] wd_count_s;
  logic            wd_zero_s;

  // Watchdog control: restart on any vector or start, run while sweeping,
  // fire only when idle in COLLECT with no vector arriving this cycle.
  always_comb begin
    wd_load_s = start || vec_valid;
    wd_en_s   = 1'b0;
    wd_fire_s = 1'b0;
    if ((state_r == ST_COLLECT) || (state_r == ST_SETTLE)) begin
      wd_en_s = 1'b1;
    end else begin
      wd_en_s = 1'b0;
    end
    if ((state_r == ST_COLLECT) && wd_zero_s && !vec_valid && !start) begin
      wd_fire_s = 1'b1;
    end else begin
      wd_fire_s = 1'b0;
    end
  end

  tt_settle_timer #(
    .W (WD_W)
  ) u_watchdog (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (wd_load_s),
    .load_val (WD_LOAD),
    .en       (wd_en_s),
    .count    (wd_count_s),
    .zero     (wd_zero_s)
  );
`else
  // Without the watchdog COLLECT waits indefinitely.
  always_comb begin
    wd_fire_s = 1'b0;
  end
`endif

  // Sample-cycle bookkeeping: coverage, mismatch and saturating error count.
  always_comb begin
    sel_s      = {{(DEPTH-1){1'b0}}, 1'b1} << idx_r;
    sample_s   = (state_r == ST_SETTLE) && settle_zero_s;
    is_new_s   = ((cov_r & sel_s) == {DEPTH{1'b0}});
    mismatch_s = (f != EXP_MASK[idx_r]);
    cov_next_s = cov_r | sel_s;
    all_cov_s  = (cov_next_s == {DEPTH{1'b1}});
    if (is_new_s && mismatch_s && (err_count_r != ERR_MAX)) begin
      err_next_s = err_count_r + ERR_ONE;
    end else begin
      err_next_s = err_count_r;
    end
  end

  // Checker FSM with all status outputs registered alongside the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r         <= ST_IDLE;
      idx_r           <= {N_IN{1'b0}};
      cov_r           <= {DEPTH{1'b0}};
      captured_r      <= {DEPTH{1'b0}};
      err_count_r     <= {(N_IN+1){1'b0}};
      first_err_idx_r <= {N_IN{1'b0}};
      busy_r          <= 1'b0;
      done_r          <= 1'b0;
      pass_r          <= 1'b0;
      dup_seen_r      <= 1'b0;
      overrun_r       <= 1'b0;
      timeout_r       <= 1'b0;
    end else if (start) begin
      // A start always wins, even over a coincident vector.
      state_r         <= ST_COLLECT;
      idx_r           <= {N_IN{1'b0}};
      cov_r           <= {DEPTH{1'b0}};
      captured_r      <= {DEPTH{1'b0}};
      err_count_r     <= {(N_IN+1){1'b0}};
      first_err_idx_r <= {N_IN{1'b0}};
      busy_r          <= 1'b1;
      done_r          <= 1'b0;
      pass_r          <= 1'b0;
      dup_seen_r      <= 1'b0;
      overrun_r       <= 1'b0;
      timeout_r       <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          state_r <= ST_IDLE;
        end
        ST_COLLECT: begin
          if (wd_fire_s) begin
            timeout_r <= 1'b1;
            state_r   <= ST_DONE;
            busy_r    <= 1'b0;
            done_r    <= 1'b1;
            pass_r    <= 1'b0;
          end else if (vec_valid) begin
            idx_r   <= vec_idx;
            state_r <= ST_SETTLE;
          end else begin
            state_r <= ST_COLLECT;
          end
        end
        ST_SETTLE: begin
          // A vector arriving mid-wait is dropped; the wait continues.
          if (vec_valid) begin
            overrun_r <= 1'b1;
          end else begin
            overrun_r <= overrun_r;
          end
          if (sample_s) begin
            if (is_new_s) begin
              captured_r[idx_r] <= f;
              cov_r             <= cov_next_s;
              err_count_r       <= err_next_s;
              if (mismatch_s && (err_count_r == {(N_IN+1){1'b0}})) begin
                first_err_idx_r <= idx_r;
              end else begin
                first_err_idx_r <= first_err_idx_r;
              end
            end else begin
              dup_seen_r <= 1'b1;
            end
            if (all_cov_s) begin
              state_r <= ST_DONE;
              busy_r  <= 1'b0;
              done_r  <= 1'b1;
              pass_r  <= (err_next_s == {(N_IN+1){1'b0}}) && !timeout_r;
            end else begin
              state_r <= ST_COLLECT;
            end
          end else begin
            state_r <= ST_SETTLE;
          end
        end
        ST_DONE: begin
          state_r <= ST_DONE;
        end
        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
          pass_r  <= 1'b0;
        end
      endcase
    end
  end

  assign busy          = busy_r;
  assign done          = done_r;
  assign pass          = pass_r;
  assign captured      = captured_r;
  assign err_count     = err_count_r;
  assign first_err_idx = first_err_idx_r;
  assign dup_seen      = dup_seen_r;
  assign overrun       = overrun_r;
  assign timeout       = timeout_r;

endmodule

// File: tb/tb_truth_table_checker.sv
// Bench for truth_table_checker: randomized sweeps checked every cycle
// against a transaction-level model, plus directed scenarios with literal
// expectations.
module tb_truth_table_checker;

  localparam int          SETTLE  = 3;
  localparam int          TIMEOUT = 64;
  localparam logic [15:0] EXP     = 16'h6996;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        vec_valid;
  logic [3:0]  vec_idx;
  logic        f;
  logic        busy;
  logic        done;
  logic        pass;
  logic [15:0] captured;
  logic [4:0]  err_count;
  logic [3:0]  first_err_idx;
  logic        dup_seen;
  logic        overrun;
  logic        timeout;

  int total = 0;
  int bad   = 0;

  truth_table_checker #(
    .N_IN     (4),
    .EXP_MASK (EXP),
    .SETTLE   (SETTLE),
    .TIMEOUT  (TIMEOUT)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .vec_valid     (vec_valid),
    .vec_idx       (vec_idx),
    .f             (f),
    .busy          (busy),
    .done          (done),
    .pass          (pass),
    .captured      (captured),
    .err_count     (err_count),
    .first_err_idx (first_err_idx),
    .dup_seen      (dup_seen),
    .overrun       (overrun),
    .timeout       (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  // A vector accepted at cycle c is sampled at cycle c+SETTLE; any vector in
  // between is dropped. The table finishes when all 16 rows are covered.
  int          cyc          = 0;
  bit          m_active     = 0;
  bit          m_done       = 0;
  bit          m_pass       = 0;
  bit          m_dup        = 0;
  bit          m_over       = 0;
  bit          m_to         = 0;
  logic [15:0] m_cap        = 16'h0000;
  logic [15:0] m_cov        = 16'h0000;
  int          m_err        = 0;
  int          m_first      = 0;
  bit          m_pend       = 0;
  int          m_pidx       = 0;
  int          m_sample_cyc = 0;
  int          m_last_act   = 0;
  logic [15:0] exp_v        = EXP;

  task automatic model_clear();
    m_done = 0; m_pass = 0; m_dup = 0; m_over = 0; m_to = 0;
    m_cap = 16'h0000; m_cov = 16'h0000; m_err = 0; m_first = 0; m_pend = 0;
  endtask

  task automatic model_sample();
    if (!m_cov[m_pidx]) begin
      m_cov[m_pidx] = 1'b1;
      m_cap[m_pidx] = f;
      if (f !== exp_v[m_pidx]) begin
        if (m_err == 0) m_first = m_pidx;
        if (m_err < 16) m_err++;
      end
      if (m_cov == 16'hFFFF) begin
        m_done = 1;
        m_pass = (m_err == 0) && !m_to;
      end
    end else begin
      m_dup = 1;
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      model_clear();
      m_active = 0;
    end else begin
      if (start) begin
        model_clear();
        m_active   = 1;
        m_last_act = cyc;
      end else if (m_active && !m_done) begin
        if (m_pend) begin
          if (vec_valid) m_over = 1;
          if (cyc == m_sample_cyc) begin
            model_sample();
            m_pend = 0;
          end
        end else if (vec_valid) begin
          m_pend       = 1;
          m_pidx       = vec_idx;
          m_sample_cyc = cyc + SETTLE;
        end
`ifdef CHECKER_TIMEOUT_EN
        else if (cyc - m_last_act >= TIMEOUT) begin
          m_to   = 1;
          m_done = 1;
          m_pass = 0;
        end
`endif
        if (vec_valid) m_last_act = cyc;
      end
      cyc++;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Cycle-by-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    check("busy",      {31'd0, busy},     {31'd0, m_active && !m_done});
    check("done",      {31'd0, done},     {31'd0, m_done});
    check("pass",      {31'd0, pass},     {31'd0, m_pass});
    check("err_count", {27'd0, err_count}, m_err);
    check("first_err", {28'd0, first_err_idx}, m_first);
    check("dup_seen",  {31'd0, dup_seen}, {31'd0, m_dup});
    check("overrun",   {31'd0, overrun},  {31'd0, m_over});
    check("timeout",   {31'd0, timeout},  {31'd0, m_to});
    check("captured",  {16'd0, captured & m_cov}, {16'd0, m_cap & m_cov});
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Apply vector idx; f is unsettled until the sample edge, then shows
  // parity(idx)^flip. ovr_k in 1..SETTLE injects a dropped vector that many
  // cycles after the pulse (0 = none).
  task automatic send(input int idx, input bit flip, input int gap,
                      input int ovr_k = 0, input int ovr_idx = 0);
    logic [3:0] iv;
    iv        = 4'(idx);
    vec_valid = 1'b1;
    vec_idx   = iv;
    f         = 1'($urandom);
    tick();
    vec_valid = 1'b0;
    for (int k = 1; k <= SETTLE; k++) begin
      if (k == ovr_k) begin
        vec_valid = 1'b1;
        vec_idx   = 4'(ovr_idx);
      end
      if (k == SETTLE) f = (^iv) ^ flip;
      else             f = 1'($urandom);
      tick();
      vec_valid = 1'b0;
    end
    tick(gap);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"},     {31'd0, busy}, 32'd0);
    check({tag, "_done"},     {31'd0, done}, 32'd0);
    check({tag, "_pass"},     {31'd0, pass}, 32'd0);
    check({tag, "_captured"}, {16'd0, captured}, 32'd0);
    check({tag, "_err"},      {27'd0, err_count}, 32'd0);
    check({tag, "_first"},    {28'd0, first_err_idx}, 32'd0);
    check({tag, "_flags"},    {29'd0, dup_seen, overrun, timeout}, 32'd0);
  endtask

  int perm[16];

  initial begin
    rst_n = 1'b0; start = 1'b0; vec_valid = 1'b0; vec_idx = 4'd0; f = 1'b0;
    tick(2);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    tick();

    // 1: parity DUT, indices in order.
    do_start();
    for (int i = 0; i < 16; i++) send(i, 1'b0, 0);
    tick();
    check("t1_done", {31'd0, done}, 32'd1);
    check("t1_pass", {31'd0, pass}, 32'd1);
    check("t1_err", {27'd0, err_count}, 32'd0);
    check("t1_captured", {16'd0, captured}, 32'h6996);

    // 2: wrong at indices 5 and 12.
    do_start();
    for (int i = 0; i < 16; i++) send(i, (i == 5) || (i == 12), 0);
    tick();
    check("t2_err", {27'd0, err_count}, 32'd2);
    check("t2_first", {28'd0, first_err_idx}, 32'd5);
    check("t2_pass", {31'd0, pass}, 32'd0);
    check("t2_done", {31'd0, done}, 32'd1);

    // 3: reverse order, index 7 repeated with flipped f.
    do_start();
    for (int i = 15; i >= 0; i--) begin
      send(i, 1'b0, 0);
      if (i == 7) send(7, 1'b1, 0);
    end
    tick();
    check("t3_dup", {31'd0, dup_seen}, 32'd1);
    check("t3_cap7", {31'd0, captured[7]}, 32'd1);
    check("t3_pass", {31'd0, pass}, 32'd1);

    // 4: second vector one cycle after the first is dropped.
    do_start();
    send(3, 1'b0, 0, 1, 4);
    for (int i = 0; i < 16; i++) if (i != 3 && i != 4) send(i, 1'b0, 1);
    check("t4_overrun", {31'd0, overrun}, 32'd1);
    check("t4_not_done", {31'd0, done}, 32'd0);
    send(4, 1'b0, 0);
    check("t4_done", {31'd0, done}, 32'd1);
    check("t4_pass", {31'd0, pass}, 32'd1);

    // 5: reset mid-sweep, then a fresh sweep.
    do_start();
    for (int i = 0; i < 8; i++) send(i, i == 2, 0);
    rst_n = 1'b0;
    #2;
    check_reset_outputs("t5_rst");
    tick(2);
    rst_n = 1'b1;
    tick();
    check("t5_idle_busy", {31'd0, busy}, 32'd0);
    do_start();
    for (int i = 0; i < 16; i++) send(15 - i, 1'b0, 0);
    check("t5_pass", {31'd0, pass}, 32'd1);

    // 6: only 10 vectors, then idle.
    do_start();
    for (int i = 0; i < 10; i++) send(i, 1'b0, 0);
    tick(TIMEOUT + 10);
`ifdef CHECKER_TIMEOUT_EN
    check("t6_timeout", {31'd0, timeout}, 32'd1);
    check("t6_done", {31'd0, done}, 32'd1);
    check("t6_pass", {31'd0, pass}, 32'd0);
`else
    check("t6_busy", {31'd0, busy}, 32'd1);
    check("t6_done", {31'd0, done}, 32'd0);
`endif

    // Randomized sweeps: shuffled order, flips, repeats, overruns, restarts.
    for (int s = 0; s < 24; s++) begin
      do_start();
      for (int i = 0; i < 16; i++) perm[i] = i;
      for (int i = 15; i > 0; i--) begin
        int j, t;
        j = $urandom_range(i, 0);
        t = perm[i]; perm[i] = perm[j]; perm[j] = t;
      end
      for (int i = 0; i < 16; i++) begin
        bit flip;
        int ok;
        flip = ($urandom_range(7, 0) == 0);
        ok   = ($urandom_range(9, 0) == 0) ? $urandom_range(SETTLE, 1) : 0;
        send(perm[i], flip, $urandom_range(2, 0), ok, $urandom_range(15, 0));
        if ($urandom_range(9, 0) == 0) send(perm[i], 1'($urandom), 0);
        if ($urandom_range(60, 0) == 0) begin
          start = 1'b1;
          vec_valid = 1'b1;
          vec_idx = 4'($urandom_range(15, 0));
          tick();
          start = 1'b0;
          vec_valid = 1'b0;
        end
      end
      tick(3);
    end

    tick(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
